// File: rtl/counter8_ctrl_pkg.sv
// Shared types and constants for the counter8 job sequencer.
package counter8_ctrl_pkg;

  localparam int LEN_W_DEF  = 8;
  localparam int DATA_W_DEF = 8;

  // Requester IDs double as bit positions in the arbiter request/grant vectors.
  localparam logic REQ_ID_UP = 1'b0;
  localparam logic REQ_ID_DN = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ARM  = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4,
    ST_ABRT = 3'd5
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the registered pointer remembers the last winner.
module rr_arb2
  import counter8_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic [1:0] gnt_o,
  output logic       last_o
);

  logic last_q, last_d;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    gnt_o  = 2'b00;
    last_d = last_q;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_q == REQ_ID_DN) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
    if (adv_i && (gnt_o != 2'b00)) begin
      last_d = gnt_o[REQ_ID_DN] ? REQ_ID_DN : REQ_ID_UP;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      last_q <= REQ_ID_DN;
    end else begin
      last_q <= last_d;
    end
  end

  assign last_o = last_q;

endmodule

// File: rtl/counter8_ctrl.sv
// Job sequencer: arbitrates up/down jobs and drives the control pins of one counter8.
module counter8_ctrl
  import counter8_ctrl_pkg::*;
#(
  parameter int LEN_W  = LEN_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ_UP,
  input  logic [DATA_W-1:0] START_UP,
  input  logic [LEN_W-1:0]  LEN_UP,
  input  logic              REQ_DN,
  input  logic [DATA_W-1:0] START_DN,
  input  logic [LEN_W-1:0]  LEN_DN,
  input  logic              PAUSE,
  input  logic              ABORT,
  output logic              GNT_UP,
  output logic              GNT_DN,
  output logic              DONE_UP,
  output logic              DONE_DN,
  output logic              ABT_UP,
  output logic              ABT_DN,
  output logic              BUSY,
  output logic              CNT_INC_START,
  output logic              CNT_INC_END,
  output logic              CNT_DEC_START,
  output logic              CNT_DEC_END,
  output logic              CNT_MODE_SEL,
  output logic              CNT_CLR,
  output logic              CNT_HOLD,
  output logic              CNT_LOAD,
  output logic [DATA_W-1:0] CNT_DIN
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [1:0]          arb_req, arb_gnt;
  logic                last_win;
  logic                up_job;
  logic                final_step;

  // Requests are only offered to the arbiter when a grant is actually allowed.
  assign arb_req = {REQ_DN, REQ_UP} & {2{(state_q == ST_IDLE) && !ABORT && !RESET}};

  rr_arb2 u_arb (
    .clk    (CLK),
    .rst    (RESET),
    .req_i  (arb_req),
    .adv_i  (state_q == ST_IDLE),
    .gnt_o  (arb_gnt),
    .last_o (last_win)
  );

  // The last winner is also the owner of the job in flight, and fixes its direction.
  assign up_job     = (last_win == REQ_ID_UP);
  assign final_step = (state_q == ST_RUN) && !PAUSE && !ABORT && (rem_q == LEN_W'(1));

  always_comb begin
    state_d = state_q;
    din_d   = din_q;
    len_d   = len_q;
    rem_d   = rem_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_gnt != 2'b00) begin
          din_d   = arb_gnt[REQ_ID_UP] ? START_UP : START_DN;
          len_d   = arb_gnt[REQ_ID_UP] ? LEN_UP : LEN_DN;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: state_d = (len_q != '0) ? ST_ARM : ST_DONE;
      ST_ARM: begin
        rem_d   = len_q;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!PAUSE) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ABRT: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (ABORT && (state_q inside {ST_LOAD, ST_ARM, ST_RUN, ST_DONE})) begin
      state_d = ST_ABRT;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      din_q   <= '0;
      len_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    GNT_UP        = arb_gnt[REQ_ID_UP];
    GNT_DN        = arb_gnt[REQ_ID_DN];
    DONE_UP       = (state_q == ST_DONE) && up_job;
    DONE_DN       = (state_q == ST_DONE) && !up_job;
    ABT_UP        = (state_q == ST_ABRT) && up_job;
    ABT_DN        = (state_q == ST_ABRT) && !up_job;
    BUSY          = (state_q != ST_IDLE);
    CNT_LOAD      = (state_q == ST_LOAD);
    CNT_INC_START = (state_q == ST_ARM) && up_job;
    CNT_DEC_START = (state_q == ST_ARM) && !up_job;
    CNT_INC_END   = final_step && up_job;
    CNT_DEC_END   = final_step && !up_job;
    CNT_HOLD      = (state_q == ST_RUN) && PAUSE;
    CNT_CLR       = (state_q == ST_ABRT);
    CNT_MODE_SEL  = up_job;
    CNT_DIN       = din_q;
  end

endmodule

// File: tb/tb_counter8_ctrl.sv
// Directed bench for counter8_ctrl with a small behavioural counter8 on its control pins.
module tb_counter8_ctrl;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       REQ_UP = 1'b0, REQ_DN = 1'b0, PAUSE = 1'b0, ABORT = 1'b0;
  logic [7:0] START_UP = '0, START_DN = '0, LEN_UP = '0, LEN_DN = '0;
  logic       GNT_UP, GNT_DN, DONE_UP, DONE_DN, ABT_UP, ABT_DN, BUSY;
  logic       CNT_INC_START, CNT_INC_END, CNT_DEC_START, CNT_DEC_END;
  logic       CNT_MODE_SEL, CNT_CLR, CNT_HOLD, CNT_LOAD;
  logic [7:0] CNT_DIN;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  counter8_ctrl dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_UP(REQ_UP), .START_UP(START_UP), .LEN_UP(LEN_UP),
    .REQ_DN(REQ_DN), .START_DN(START_DN), .LEN_DN(LEN_DN),
    .PAUSE(PAUSE), .ABORT(ABORT),
    .GNT_UP(GNT_UP), .GNT_DN(GNT_DN), .DONE_UP(DONE_UP), .DONE_DN(DONE_DN),
    .ABT_UP(ABT_UP), .ABT_DN(ABT_DN), .BUSY(BUSY),
    .CNT_INC_START(CNT_INC_START), .CNT_INC_END(CNT_INC_END),
    .CNT_DEC_START(CNT_DEC_START), .CNT_DEC_END(CNT_DEC_END),
    .CNT_MODE_SEL(CNT_MODE_SEL), .CNT_CLR(CNT_CLR), .CNT_HOLD(CNT_HOLD),
    .CNT_LOAD(CNT_LOAD), .CNT_DIN(CNT_DIN)
  );

  // Control vector order: gnt_up gnt_dn | load | inc_s inc_e dec_s dec_e | hold clr | done_up done_dn abt_up abt_dn | busy
  logic [13:0] ctl;
  assign ctl = {GNT_UP, GNT_DN, CNT_LOAD, CNT_INC_START, CNT_INC_END, CNT_DEC_START, CNT_DEC_END,
                CNT_HOLD, CNT_CLR, DONE_UP, DONE_DN, ABT_UP, ABT_DN, BUSY};

  // counter8 stand-in: start pulse arms counting, each unheld edge steps, end pulse's edge is the last step.
  logic [7:0] dout_m;
  logic       run_m;
  always @(posedge CLK) begin
    if (RESET || CNT_CLR) begin
      dout_m <= 8'h00;
      run_m  <= 1'b0;
    end else if (CNT_LOAD) begin
      dout_m <= CNT_DIN;
    end else begin
      if (run_m && !CNT_HOLD) dout_m <= CNT_MODE_SEL ? dout_m + 8'd1 : dout_m - 8'd1;
      if (CNT_INC_START || CNT_DEC_START) run_m <= 1'b1;
      if (CNT_INC_END || CNT_DEC_END) run_m <= 1'b0;
    end
  end

  task automatic do_reset();
    @(posedge CLK); #1;
    RESET = 1'b1; REQ_UP = 1'b0; REQ_DN = 1'b0; PAUSE = 1'b0; ABORT = 1'b0;
    START_UP = '0; START_DN = '0; LEN_UP = '0; LEN_DN = '0;
    @(posedge CLK); #1;
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge CLK); #1;
    RESET = 1'b1; REQ_UP = 1'b1; REQ_DN = 1'b1; START_UP = 8'hFF; LEN_UP = 8'd5;
    @(negedge CLK);
    vectors++;
    if (ctl !== 14'b0) begin miscompares++; $display("FAIL reset_ctl: got %b want %b", ctl, 14'b0); end
    vectors++;
    if ({CNT_DIN, CNT_MODE_SEL} !== 9'h000) begin
      miscompares++; $display("FAIL reset_din_mode: got %h/%b want 00/0", CNT_DIN, CNT_MODE_SEL);
    end
    @(posedge CLK); #1;
    RESET = 1'b0; REQ_UP = 1'b0; REQ_DN = 1'b0;
    @(negedge CLK);
    vectors++;
    if (ctl !== 14'b0) begin miscompares++; $display("FAIL reset_idle_ctl: got %b want %b", ctl, 14'b0); end
  endtask

  task automatic test_up_basic();
    logic [13:0] exp_c [8];
    logic [7:0]  exp_d [8];
    exp_c = '{14'b10_0_0000_00_0000_0, 14'b00_1_0000_00_0000_1, 14'b00_0_1000_00_0000_1,
              14'b00_0_0000_00_0000_1, 14'b00_0_0000_00_0000_1, 14'b00_0_0100_00_0000_1,
              14'b00_0_0000_00_1000_1, 14'b00_0_0000_00_0000_0};
    exp_d = '{8'h00, 8'h00, 8'h10, 8'h10, 8'h11, 8'h12, 8'h13, 8'h13};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK); #1;
      REQ_UP = (i == 0);
      START_UP = (i == 0) ? 8'h10 : 8'hFF;
      LEN_UP = (i == 0) ? 8'd3 : 8'd9;
      @(negedge CLK);
      vectors++;
      if (ctl !== exp_c[i]) begin miscompares++; $display("FAIL up_basic_ctl cyc %0d: got %b want %b", i, ctl, exp_c[i]); end
      vectors++;
      if (dout_m !== exp_d[i]) begin miscompares++; $display("FAIL up_basic_dout cyc %0d: got %h want %h", i, dout_m, exp_d[i]); end
      vectors++;
      if (CNT_MODE_SEL !== (i != 0)) begin miscompares++; $display("FAIL up_basic_mode cyc %0d: got %b want %b", i, CNT_MODE_SEL, i != 0); end
      if (i >= 1) begin
        vectors++;
        if (CNT_DIN !== 8'h10) begin miscompares++; $display("FAIL up_basic_din cyc %0d: got %h want 10", i, CNT_DIN); end
      end
    end
  endtask

  task automatic test_dn_basic();
    logic [13:0] exp_c [9];
    logic [7:0]  exp_d [9];
    exp_c = '{14'b01_0_0000_00_0000_0, 14'b00_1_0000_00_0000_1, 14'b00_0_0010_00_0000_1,
              14'b00_0_0000_00_0000_1, 14'b00_0_0000_00_0000_1, 14'b00_0_0000_00_0000_1,
              14'b00_0_0001_00_0000_1, 14'b00_0_0000_00_0100_1, 14'b00_0_0000_00_0000_0};
    exp_d = '{8'h00, 8'h00, 8'h02, 8'h02, 8'h01, 8'h00, 8'hFF, 8'hFE, 8'hFE};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      @(posedge CLK); #1;
      REQ_DN = (i == 0);
      START_DN = 8'h02;
      LEN_DN = (i >= 3) ? 8'd9 : 8'd4;
      @(negedge CLK);
      vectors++;
      if (ctl !== exp_c[i]) begin miscompares++; $display("FAIL dn_basic_ctl cyc %0d: got %b want %b", i, ctl, exp_c[i]); end
      vectors++;
      if (dout_m !== exp_d[i]) begin miscompares++; $display("FAIL dn_basic_dout cyc %0d: got %h want %h", i, dout_m, exp_d[i]); end
      vectors++;
      if (CNT_MODE_SEL !== 1'b0) begin miscompares++; $display("FAIL dn_basic_mode cyc %0d: got %b want 0", i, CNT_MODE_SEL); end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_s;
    @(posedge CLK); #1;
    RESET = 1'b1; REQ_UP = 1'b1; REQ_DN = 1'b1; PAUSE = 1'b0; ABORT = 1'b0;
    START_UP = 8'h20; LEN_UP = 8'd1; START_DN = 8'h40; LEN_DN = 8'd1;
    // LEN=1 jobs take 5 cycles each (GNT, LOAD, ARM, RUN, DONE) and alternate UP, DN.
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      RESET = 1'b0;
      @(negedge CLK);
      exp_s = {(i % 10) == 0, (i % 10) == 5, (i % 10) == 4, (i % 10) == 9, (i % 5) != 0};
      vectors++;
      if ({GNT_UP, GNT_DN, DONE_UP, DONE_DN, BUSY} !== exp_s) begin
        miscompares++; $display("FAIL b2b_seq cyc %0d: got %b want %b", i, {GNT_UP, GNT_DN, DONE_UP, DONE_DN, BUSY}, exp_s);
      end
      if ((i % 5) == 4) begin
        vectors++;
        if (dout_m !== (((i % 10) == 4) ? 8'h21 : 8'h3F)) begin
          miscompares++; $display("FAIL b2b_dout cyc %0d: got %h want %h", i, dout_m, ((i % 10) == 4) ? 8'h21 : 8'h3F);
        end
      end
    end
    REQ_UP = 1'b0; REQ_DN = 1'b0;
  endtask

  task automatic test_pause();
    logic [13:0] exp_c [12];
    logic [7:0]  exp_d [12];
    exp_c = '{14'b10_0_0000_00_0000_0, 14'b00_1_0000_00_0000_1, 14'b00_0_1000_00_0000_1,
              14'b00_0_0000_00_0000_1, 14'b00_0_0000_00_0000_1, 14'b00_0_0000_10_0000_1,
              14'b00_0_0000_10_0000_1, 14'b00_0_0000_00_0000_1, 14'b00_0_0000_00_0000_1,
              14'b00_0_0100_00_0000_1, 14'b00_0_0000_00_1000_1, 14'b00_0_0000_00_0000_0};
    exp_d = '{8'h00, 8'h00, 8'h30, 8'h30, 8'h31, 8'h32, 8'h32, 8'h32, 8'h33, 8'h34, 8'h35, 8'h35};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK); #1;
      REQ_UP = (i == 0); START_UP = 8'h30; LEN_UP = 8'd5;
      PAUSE = (i == 5) || (i == 6);
      @(negedge CLK);
      vectors++;
      if (ctl !== exp_c[i]) begin miscompares++; $display("FAIL pause_ctl cyc %0d: got %b want %b", i, ctl, exp_c[i]); end
      vectors++;
      if (dout_m !== exp_d[i]) begin miscompares++; $display("FAIL pause_dout cyc %0d: got %h want %h", i, dout_m, exp_d[i]); end
    end
  endtask

  task automatic test_abort();
    logic [13:0] exp_c [12];
    logic [7:0]  exp_d [12];
    exp_c = '{14'b01_0_0000_00_0000_0, 14'b00_1_0000_00_0000_1, 14'b00_0_0010_00_0000_1,
              14'b00_0_0000_00_0000_1, 14'b00_0_0000_00_0000_1, 14'b00_0_0000_01_0001_1,
              14'b10_0_0000_00_0000_0, 14'b00_1_0000_00_0000_1, 14'b00_0_1000_00_0000_1,
              14'b00_0_0100_00_0000_1, 14'b00_0_0000_00_1000_1, 14'b00_0_0000_00_0000_0};
    exp_d = '{8'h00, 8'h00, 8'h50, 8'h50, 8'h4F, 8'h4E, 8'h00, 8'h00, 8'h77, 8'h77, 8'h78, 8'h78};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK); #1;
      REQ_DN = (i == 0); START_DN = 8'h50; LEN_DN = 8'd6;
      REQ_UP = (i == 6); START_UP = 8'h77; LEN_UP = 8'd1;
      ABORT = (i == 4);
      @(negedge CLK);
      vectors++;
      if (ctl !== exp_c[i]) begin miscompares++; $display("FAIL abort_ctl cyc %0d: got %b want %b", i, ctl, exp_c[i]); end
      vectors++;
      if (dout_m !== exp_d[i]) begin miscompares++; $display("FAIL abort_dout cyc %0d: got %h want %h", i, dout_m, exp_d[i]); end
    end
  endtask

  task automatic test_len_zero();
    logic [13:0] exp_c [4];
    logic [7:0]  exp_d [4];
    exp_c = '{14'b10_0_0000_00_0000_0, 14'b00_1_0000_00_0000_1,
              14'b00_0_0000_00_1000_1, 14'b00_0_0000_00_0000_0};
    exp_d = '{8'h00, 8'h00, 8'hA5, 8'hA5};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      REQ_UP = (i == 0); START_UP = 8'hA5; LEN_UP = 8'd0;
      @(negedge CLK);
      vectors++;
      if (ctl !== exp_c[i]) begin miscompares++; $display("FAIL len0_ctl cyc %0d: got %b want %b", i, ctl, exp_c[i]); end
      vectors++;
      if (dout_m !== exp_d[i]) begin miscompares++; $display("FAIL len0_dout cyc %0d: got %h want %h", i, dout_m, exp_d[i]); end
    end
  endtask

  task automatic test_idle_abort();
    logic [13:0] exp_c [5];
    exp_c = '{14'b00_0_0000_00_0000_0, 14'b10_0_0000_00_0000_0, 14'b00_1_0000_00_0000_1,
              14'b00_0_0000_00_1000_1, 14'b00_0_0000_00_0000_0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      REQ_UP = (i <= 1); START_UP = 8'h11; LEN_UP = 8'd0;
      ABORT = (i == 0);
      @(negedge CLK);
      vectors++;
      if (ctl !== exp_c[i]) begin miscompares++; $display("FAIL idle_abort_ctl cyc %0d: got %b want %b", i, ctl, exp_c[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [13:0] exp_c [8];
    logic [7:0]  exp_d [8];
    exp_c = '{14'b10_0_0000_00_0000_0, 14'b00_1_0000_00_0000_1, 14'b00_0_1000_00_0000_1,
              14'b00_0_0000_00_0000_1, 14'b00_0_0000_00_0000_1, 14'b00_0_0000_00_0000_0,
              14'b00_0_0000_00_0000_0, 14'b00_0_0000_00_0000_0};
    exp_d = '{8'h00, 8'h00, 8'h60, 8'h60, 8'h61, 8'h00, 8'h00, 8'h00};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK); #1;
      REQ_UP = (i == 0); START_UP = 8'h60; LEN_UP = 8'd4;
      RESET = (i == 4);
      @(negedge CLK);
      vectors++;
      if (ctl !== exp_c[i]) begin miscompares++; $display("FAIL reset_mid_ctl cyc %0d: got %b want %b", i, ctl, exp_c[i]); end
      vectors++;
      if (dout_m !== exp_d[i]) begin miscompares++; $display("FAIL reset_mid_dout cyc %0d: got %h want %h", i, dout_m, exp_d[i]); end
      if (i >= 5) begin
        vectors++;
        if ({CNT_DIN, CNT_MODE_SEL} !== 9'h000) begin
          miscompares++; $display("FAIL reset_mid_din_mode cyc %0d: got %h/%b want 00/0", i, CNT_DIN, CNT_MODE_SEL);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_basic();
    test_dn_basic();
    test_back_to_back();
    test_pause();
    test_abort();
    test_len_zero();
    test_idle_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
